// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a 4:1 mux: dwells on each active channel, samples Y, hands it off.
// Optional MUX_SCAN_PARITY_EN adds out_parity, the XOR-reduction of the captured word.
module mux_scan_ctrl #(
  parameter int WIDTH = 4,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       req,
  output logic             S1,
  output logic             S0,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             busy_q;
`ifdef MUX_SCAN_PARITY_EN
  logic             par_q, par_d;
`endif

  // First requesting channel strictly after ptr; ptr itself has lowest priority.
  function automatic logic [1:0] next_chan(input logic [1:0] ptr, input logic [3:0] r);
    logic [1:0] c;
    next_chan = ptr;
    for (int i = 4; i >= 1; i--) begin
      c = ptr + 2'(i);
      if (r[c]) next_chan = c;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && (req != 4'b0000)) begin
          sel_d   = next_chan(ptr_q, req);
          cnt_d   = CNT_LOAD;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (cnt_q == 8'd0) begin
          data_d  = Y;
          chan_d  = sel_q;
          valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          par_d   = ^Y;
`endif
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ptr_d   = chan_q;
          if (en && (req != 4'b0000)) begin
            sel_d   = next_chan(chan_q, req);
            cnt_d   = CNT_LOAD;
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= 8'd0;
      data_q  <= '0;
      chan_q  <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign S1        = sel_q[1];
  assign S0        = sel_q[0];
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
`ifdef MUX_SCAN_PARITY_EN
  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: transaction-level model compared every cycle plus directed literal scenarios.
module tb_mux_scan_ctrl;
  localparam int WIDTH = 4;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] req = 4'b0000;
  logic S1, S0, out_valid, busy;
  logic [WIDTH-1:0] Y, out_data;
  logic [1:0] out_chan;
`ifdef MUX_SCAN_PARITY_EN
  logic out_parity;
`endif

  logic [3:0] mux_tab [4] = '{4'h0, 4'hA, 4'hF, 4'h9};
  assign Y = mux_tab[{S1, S0}];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .S1(S1), .S0(S0), .Y(Y),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a selection ages DWELL cycles, then a result waits for ready.
  typedef struct {
    bit sel_on; int age; int sel; bit valid; int data; int chan; int ptr;
  } mdl_t;

  function automatic mdl_t m_reset();
    mdl_t r;
    r.sel_on = 0; r.age = 0; r.sel = 0; r.valid = 0; r.data = 0; r.chan = 0; r.ptr = 3;
    return r;
  endfunction

  function automatic int pick(input int ptr, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return ptr;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input logic e, input logic [3:0] r, input logic rdy);
    mdl_t n = m;
    if (m.sel_on) begin
      n.age = m.age + 1;
      if (n.age == DWELL) begin
        n.sel_on = 0; n.valid = 1; n.chan = m.sel; n.data = int'(mux_tab[m.sel]);
      end
    end else if (m.valid) begin
      if (rdy) begin
        n.valid = 0; n.ptr = m.chan;
        if (e && r != 0) begin n.sel = pick(m.chan, r); n.sel_on = 1; n.age = 0; end
      end
    end else if (e && r != 0) begin
      n.sel = pick(m.ptr, r); n.sel_on = 1; n.age = 0;
    end
    return n;
  endfunction

  mdl_t m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= model_next(m, en, req, out_ready);
  end

  typedef struct { int chan; int data; int cyc; } xfer_t;
  xfer_t xlog[$];
  int cyc = 0;
  bit seen[4];

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) xlog.push_back('{int'(out_chan), int'(out_data), cyc});
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    seen[{S1, S0}] = 1'b1;
    chk("model_sel", {S1, S0}, m.sel);
    chk("model_valid", out_valid, m.valid);
    chk("model_data", out_data, m.data);
    chk("model_chan", out_chan, m.chan);
    chk("model_busy", busy, m.sel_on || m.valid);
`ifdef MUX_SCAN_PARITY_EN
    chk("model_parity", out_parity, ^(4'(m.data)));
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", {S1, S0}, 2'b00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    en = 1'b0; req = 4'b0000; out_ready = 1'b1;
    xlog.delete();
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_xfers(input int n);
    int b = 0;
    while (xlog.size() < n && b < 200) begin @(negedge clk); b++; end
    chk("xfer_timeout", xlog.size() >= n, 1);
  endtask

  task automatic wait_hold(input int c);
    int b = 0;
    do begin @(negedge clk); b++; end
    while (!(out_valid === 1'b1 && out_chan == 2'(c)) && b < 200);
    chk("hold_timeout", out_valid === 1'b1 && out_chan == 2'(c), 1);
  endtask

  task automatic chk_xfer(input int idx, input int c, input int d);
    if (xlog.size() > idx) begin
      chk("xfer_chan", xlog[idx].chan, c);
      chk("xfer_data", xlog[idx].data, d);
    end else begin
      chk("xfer_missing", xlog.size(), idx + 1);
    end
  endtask

  int s0;
  int exp_c [5] = '{0, 1, 2, 3, 0};
  int exp_d [5] = '{'h0, 'hA, 'hF, 'h9, 'h0};

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-run: start scanning, then assert reset between edges.
    req = 4'b1111; en = 1'b1; out_ready = 1'b1;
    repeat (7) @(negedge clk);
    chk("busy_before_rst", busy, 1'b1);
    do_reset();

    // Full round-robin with ready tied high.
    req = 4'b1111; en = 1'b1;
    s0 = cyc;
    wait_xfers(5);
    for (int i = 0; i < 5; i++) chk_xfer(i, exp_c[i], exp_d[i]);
    if (xlog.size() >= 5) begin
      chk("first_latency", xlog[0].cyc - s0, 5);
      for (int i = 1; i < 5; i++) chk("period", xlog[i].cyc - xlog[i-1].cyc, DWELL + 1);
    end

    // Sparse mask A/C.
    do_reset();
    req = 4'b0101; en = 1'b1;
    wait_xfers(4);
    chk_xfer(0, 0, 'h0); chk_xfer(1, 2, 'hF); chk_xfer(2, 0, 'h0); chk_xfer(3, 2, 'hF);
    chk("never_sel_B", seen[1], 1'b0);
    chk("never_sel_D", seen[3], 1'b0);

    // Backpressure in HOLD on channel B.
    do_reset();
    req = 4'b1111; en = 1'b1;
    wait_hold(1);
    out_ready = 1'b0;
    chk("xfers_before_stall", xlog.size(), 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 4'hA);
      chk("stall_sel", {S1, S0}, 2'b01);
    end
    out_ready = 1'b1;
    wait_xfers(2);
    chk("xfers_after_stall", xlog.size(), 2);
    chk("advance_sel", {S1, S0}, 2'b10);
    wait_xfers(3);
    chk_xfer(1, 1, 'hA);
    chk_xfer(2, 2, 'hF);

    // Enable dropped mid-dwell on channel D.
    do_reset();
    req = 4'b1111; en = 1'b1;
    wait_hold(2);
    repeat (2) @(negedge clk);
    chk("sel_D_dwell", {S1, S0}, 2'b11);
    en = 1'b0;
    wait_xfers(4);
    chk_xfer(3, 3, 'h9);
    repeat (10) begin
      @(negedge clk);
      chk("after_en_busy", busy, 1'b0);
      chk("after_en_valid", out_valid, 1'b0);
    end
    chk("after_en_xfers", xlog.size(), 4);

    // Empty mask stays idle, then single channel D.
    do_reset();
    req = 4'b0000; en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("empty_busy", busy, 1'b0);
      chk("empty_valid", out_valid, 1'b0);
    end
    req = 4'b1000;
    wait_xfers(1);
    chk_xfer(0, 3, 'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
